// File: rtl/ndro_drv_pkg.sv
// Shared definitions for the NDRO pulse driver: command opcodes, FSM states
// and a small helper used to size the guard/window counters.
// No ports; imported by ndro_pulse_driver.
package ndro_drv_pkg;

  // cmd_op encoding
  localparam logic [1:0] OP_WR0 = 2'b00;  // reset pulse, cell stores 0
  localparam logic [1:0] OP_WR1 = 2'b01;  // set pulse, cell stores 1
  localparam logic [1:0] OP_RD  = 2'b10;  // clk pulse, non-destructive read
  localparam logic [1:0] OP_RSV = 2'b11;  // reserved, answered with an error

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GUARD     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ndro_pulse_driver_sync.sv
// Two-flop synchroniser plus previous-value register for the toggle-encoded
// ndro_out line; emits a one-cycle pulse for every synchronised transition.
// Ports: clk, reset (async, active-high), tog_i (raw async line), edge_o (pulse).
module sfq_toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic tog_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // All three flops take the live line level during reset so that leaving
  // reset never looks like a transition, whatever state the cell is in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= tog_i;
      sync_q <= tog_i;
      prev_q <= tog_i;
    end else begin
      meta_q <= tog_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = sync_q ^ prev_q;

endmodule

// File: rtl/ndro_pulse_driver.sv
// Drives one RSFQ NDRO cell through toggle-encoded set/reset/clk lines from
// valid/ready commands, enforces pulse spacing with guard counters, and
// returns one response (data/err) per command with a valid/ready handshake.
// Ports: clk, reset (async, active-high); cmd_valid/cmd_ready/cmd_op;
//        rsp_valid/rsp_ready/rsp_data/rsp_err; ndro_set/ndro_reset/ndro_clk
//        (toggle outputs); ndro_out (async toggle input); busy.
module ndro_pulse_driver
  import ndro_drv_pkg::*;
#(
  parameter int RST_SET_GAP = 2,
  parameter int CLK_RST_GAP = 2,
  parameter int CLK_CLK_GAP = 8,
  parameter int RESP_WIN    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_data,
  output logic       rsp_err,
  output logic       ndro_set,
  output logic       ndro_reset,
  output logic       ndro_clk,
  input  logic       ndro_out,
  output logic       busy
);

  localparam int CW = $clog2(max_int(max_int(RST_SET_GAP, CLK_RST_GAP),
                                     max_int(CLK_CLK_GAP, RESP_WIN)) + 1);

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          shadow_q, shadow_d;
  logic          stray_q, stray_d;
  logic          set_line_q, set_line_d;
  logic          rst_line_q, rst_line_d;
  logic          clk_line_q, clk_line_d;
  logic [CW-1:0] set_gd_q, set_gd_d;
  logic [CW-1:0] rst_gd_q, rst_gd_d;
  logic [CW-1:0] clk_gd_q, clk_gd_d;
  logic [CW-1:0] win_q, win_d;
  logic          rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic          out_edge;
  logic          stray_evt;
  logic          stray_now;
  logic [1:0]    op_sel;
  logic [CW-1:0] set_gd_dec, rst_gd_dec, clk_gd_dec, sel_dec;
  logic          guard_clear;

  sfq_toggle_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .tog_i  (ndro_out),
    .edge_o (out_edge)
  );

  // Saturating per-cycle decrement of every guard.
  assign set_gd_dec = (set_gd_q == '0) ? '0 : set_gd_q - 1'b1;
  assign rst_gd_dec = (rst_gd_q == '0) ? '0 : rst_gd_q - 1'b1;
  assign clk_gd_dec = (clk_gd_q == '0) ? '0 : clk_gd_q - 1'b1;

  // Guard that applies to the command being accepted (IDLE) or waiting (GUARD).
  always_comb begin
    op_sel = (state_q == ST_IDLE) ? cmd_op : op_q;
    case (op_sel)
      OP_WR0:  sel_dec = rst_gd_dec;
      OP_WR1:  sel_dec = set_gd_dec;
      default: sel_dec = clk_gd_dec;
    endcase
  end

  // A guard loaded with GAP in an ISSUE cycle holds GAP on the following
  // cycle, so its value is 1 exactly GAP cycles after the previous toggle
  // edge. Entering ISSUE when the next value is <= 1 places the new toggle
  // edge GAP cycles after the previous one, never earlier.
  assign guard_clear = (sel_dec <= CW'(1));

  // Out transitions seen while not waiting for read data are stray.
  assign stray_evt = out_edge && (state_q != ST_READ_WAIT);
  assign stray_now = stray_q | stray_evt;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    shadow_d   = shadow_q;
    stray_d    = stray_now;
    set_line_d = set_line_q;
    rst_line_d = rst_line_q;
    clk_line_d = clk_line_q;
    set_gd_d   = set_gd_dec;
    rst_gd_d   = rst_gd_dec;
    clk_gd_d   = clk_gd_dec;
    win_d      = win_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    // On every entry to RESP the pending stray flag is folded into rsp_err
    // and cleared; a transition arriving while the response is held then
    // sets it again for the next response instead of being lost.
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (cmd_op == OP_RSV) begin
            state_d    = ST_RESP;
            rsp_data_d = shadow_q;
            rsp_err_d  = 1'b1;
            stray_d    = 1'b0;
          end else begin
            state_d = guard_clear ? ST_ISSUE : ST_GUARD;
          end
        end
      end

      ST_GUARD: begin
        if (guard_clear) begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        case (op_q)
          OP_WR0: begin
            rst_line_d = ~rst_line_q;
            shadow_d   = 1'b0;
            set_gd_d   = CW'(RST_SET_GAP);
            rsp_data_d = 1'b0;
            rsp_err_d  = stray_now;
            stray_d    = 1'b0;
            state_d    = ST_RESP;
          end
          OP_WR1: begin
            set_line_d = ~set_line_q;
            shadow_d   = 1'b1;
            rsp_data_d = 1'b1;
            rsp_err_d  = stray_now;
            stray_d    = 1'b0;
            state_d    = ST_RESP;
          end
          default: begin
            clk_line_d = ~clk_line_q;
            rst_gd_d   = CW'(CLK_RST_GAP);
            clk_gd_d   = CW'(CLK_CLK_GAP);
            win_d      = CW'(RESP_WIN);
            state_d    = ST_READ_WAIT;
          end
        endcase
      end

      ST_READ_WAIT: begin
        if (out_edge) begin
          rsp_data_d = 1'b1;
          rsp_err_d  = ~shadow_q | stray_q;
          stray_d    = 1'b0;
          state_d    = ST_RESP;
        end else if (win_q == '0) begin
          rsp_data_d = 1'b0;
          rsp_err_d  = shadow_q | stray_q;
          stray_d    = 1'b0;
          state_d    = ST_RESP;
        end else begin
          win_d = win_q - 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WR0;
      shadow_q   <= 1'b0;
      stray_q    <= 1'b0;
      set_line_q <= 1'b0;
      rst_line_q <= 1'b0;
      clk_line_q <= 1'b0;
      set_gd_q   <= '0;
      rst_gd_q   <= '0;
      clk_gd_q   <= '0;
      win_q      <= '0;
      rsp_data_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      shadow_q   <= shadow_d;
      stray_q    <= stray_d;
      set_line_q <= set_line_d;
      rst_line_q <= rst_line_d;
      clk_line_q <= clk_line_d;
      set_gd_q   <= set_gd_d;
      rst_gd_q   <= rst_gd_d;
      clk_gd_q   <= clk_gd_d;
      win_q      <= win_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE) && !reset;
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign ndro_set   = set_line_q;
  assign ndro_reset = rst_line_q;
  assign ndro_clk   = clk_line_q;

endmodule

// File: tb/tb_ndro_pulse_driver.sv
// Testbench for ndro_pulse_driver: directed steps plus randomized commands
// checked against a cycle-level behavioural model of pulse spacing, shadow
// state, stray-edge reporting and response timing.
module tb_ndro_pulse_driver;

  localparam int RST_SET_GAP = 2;
  localparam int CLK_RST_GAP = 2;
  localparam int CLK_CLK_GAP = 8;
  localparam int RESP_WIN    = 10;
  localparam int SYNC_LAT    = 2;   // cycles from line change to detect
  localparam logic [1:0] W0 = 2'b00, W1 = 2'b01, RD = 2'b10, RSV = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic rsp_valid, rsp_ready, rsp_data, rsp_err;
  logic ndro_set, ndro_reset, ndro_clk, ndro_out, busy;

  ndro_pulse_driver #(
    .RST_SET_GAP(RST_SET_GAP), .CLK_RST_GAP(CLK_RST_GAP),
    .CLK_CLK_GAP(CLK_CLK_GAP), .RESP_WIN(RESP_WIN)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .ndro_set(ndro_set),
    .ndro_reset(ndro_reset), .ndro_clk(ndro_clk), .ndro_out(ndro_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Cycle index and line-flip monitor (flip cycle = first cycle new level seen).
  int cyc = 0;
  int set_flip = 0, rst_flip = 0, clk_flip = 0;
  int n_set = 0, n_rst = 0, n_clk = 0;
  logic p_set, p_rst, p_clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      p_set <= ndro_set;
      p_rst <= ndro_reset;
      p_clk <= ndro_clk;
    end else begin
      if (ndro_set !== p_set) begin n_set <= n_set + 1; set_flip <= cyc; end
      if (ndro_reset !== p_rst) begin n_rst <= n_rst + 1; rst_flip <= cyc; end
      if (ndro_clk !== p_clk) begin n_clk <= n_clk + 1; clk_flip <= cyc; end
      p_set <= ndro_set;
      p_rst <= ndro_reset;
      p_clk <= ndro_clk;
    end
  end

  // Behavioural model state.
  logic m_shadow = 1'b0;
  logic m_stray  = 1'b0;
  int   m_set = -1000, m_rst = -1000, m_clk = -1000;
  int   e_set = 0, e_rst = 0, e_clk = 0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_nset"}, n_set, e_set);
    chk({tag, "_nrst"}, n_rst, e_rst);
    chk({tag, "_nclk"}, n_clk, e_clk);
  endtask

  // Issue one command; tog_at = cycles after the clk flip at which ndro_out
  // is toggled (-1: no toggle); rdy_wait = cycles the response is held.
  task automatic run_cmd(input string tag, input logic [1:0] op, input int tog_at,
                         input int rdy_wait);
    int acc, rspc, exp_f, exp_r, nclk0;
    logic exp_d, exp_e;
    bit ok, toggled;
    acc = 0; rspc = 0; exp_f = 0; exp_r = 0;
    nclk0 = n_clk;
    cmd_op = op;
    cmd_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin ok = 1; acc = cyc; break; end
      step();
    end
    chk({tag, "_accept"}, ok, 1);
    step();
    cmd_valid = 1'b0;

    exp_d = m_shadow;
    exp_e = 1'b1;
    case (op)
      W0: begin
        exp_f = imax(acc + 2, m_clk + CLK_RST_GAP);
        m_rst = exp_f; e_rst++; m_shadow = 1'b0;
        exp_r = exp_f; exp_d = 1'b0; exp_e = m_stray;
      end
      W1: begin
        exp_f = imax(acc + 2, m_rst + RST_SET_GAP);
        m_set = exp_f; e_set++; m_shadow = 1'b1;
        exp_r = exp_f; exp_d = 1'b1; exp_e = m_stray;
      end
      RD: begin
        exp_f = imax(acc + 2, m_clk + CLK_CLK_GAP);
        m_clk = exp_f; e_clk++;
        if (tog_at >= 0 && tog_at + SYNC_LAT <= RESP_WIN) begin
          exp_d = 1'b1; exp_r = exp_f + tog_at + SYNC_LAT + 1;
        end else begin
          exp_d = 1'b0; exp_r = exp_f + RESP_WIN + 1;
        end
        exp_e = (exp_d != m_shadow) | m_stray;
      end
      default: begin
        exp_r = acc + 1; exp_d = m_shadow; exp_e = 1'b1;
      end
    endcase
    m_stray = 1'b0;

    ok = 0; toggled = 0;
    for (int k = 0; k < 100; k++) begin
      if (op == RD && tog_at >= 0 && !toggled && n_clk != nclk0 && cyc == clk_flip + tog_at) begin
        ndro_out = ~ndro_out;
        toggled = 1;
      end
      if (rsp_valid) begin ok = 1; rspc = cyc; break; end
      step();
    end
    chk({tag, "_rsp_seen"}, ok, 1);
    chk({tag, "_rsp_cycle"}, rspc, exp_r);
    chk({tag, "_rsp_data"}, rsp_data, exp_d);
    chk({tag, "_rsp_err"}, rsp_err, exp_e);
    case (op)
      W0: chk({tag, "_flip_cycle"}, rst_flip, exp_f);
      W1: chk({tag, "_flip_cycle"}, set_flip, exp_f);
      RD: chk({tag, "_flip_cycle"}, clk_flip, exp_f);
      default: ;
    endcase
    chk_counts(tag);
    for (int k = 0; k < rdy_wait; k++) begin
      step();
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_data"}, rsp_data, exp_d);
      chk({tag, "_hold_err"}, rsp_err, exp_e);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_idle_after"}, cmd_ready, 1);
  endtask

  task automatic stray_toggle();
    ndro_out = ~ndro_out;
    m_stray = 1'b1;
    repeat (4) step();
  endtask

  initial begin : main
    int f1, n0;
    bit ok;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; rsp_ready = 1'b0; ndro_out = 1'b0;
    repeat (3) step();
    chk("in_reset_ready", cmd_ready, 0);
    chk("in_reset_valid", rsp_valid, 0);
    reset = 1'b0;
    step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_lines", {ndro_set, ndro_reset, ndro_clk}, 3'b000);

    // write1 then read with out toggling 7 cycles after the clk flip
    run_cmd("w1_a", W1, -1, 0);
    run_cmd("rd_a", RD, 7, 1);

    // write0 immediately followed by write1
    run_cmd("w0_b", W0, -1, 0);
    run_cmd("w1_b", W1, -1, 0);
    n_assert++;
    assert ((set_flip - rst_flip) >= RST_SET_GAP) else begin
      n_fail++;
      $error("FAIL w0w1_gap: observed %0d expected >= %0d", set_flip - rst_flip, RST_SET_GAP);
    end

    // back-to-back reads in state 1, response taken immediately
    run_cmd("rd_c1", RD, 1, 0);
    f1 = clk_flip;
    run_cmd("rd_c2", RD, 2, 0);
    chk("rd_rd_gap", clk_flip - f1, CLK_CLK_GAP);

    // read with no out activity: window expiry, shadow mismatch
    run_cmd("rd_d", RD, -1, 2);

    // stray toggle while idle, then write0 and a quiet read
    stray_toggle();
    run_cmd("w0_e", W0, -1, 0);
    run_cmd("rd_e", RD, -1, 0);

    // reset one cycle into READ_WAIT
    run_cmd("w1_f", W1, -1, 0);
    cmd_op = RD; cmd_valid = 1'b1;
    n0 = n_clk;
    step();
    cmd_valid = 1'b0;
    e_clk++;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      if (n_clk != n0) begin ok = 1; break; end
      step();
    end
    chk("abort_flip_seen", ok, 1);
    step();
    reset = 1'b1;
    step();
    chk("abort_valid", rsp_valid, 0);
    chk("abort_lines", {ndro_set, ndro_reset, ndro_clk}, 3'b000);
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    m_shadow = 1'b0; m_stray = 1'b0;
    m_set = -1000; m_rst = -1000; m_clk = -1000;
    step();
    chk("abort_ready", cmd_ready, 1);
    repeat (12) step();
    chk("abort_no_rsp", rsp_valid, 0);
    chk_counts("abort");
    run_cmd("rsv_f", RSV, -1, 1);

    // randomized command stream
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      int tg, rw;
      if ($urandom_range(0, 4) == 0) stray_toggle();
      op = 2'($urandom_range(0, 3));
      tg = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 6));
      rw = int'($urandom_range(0, 3));
      run_cmd("rand", op, tg, rw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
